// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signal bundle for icache_responder.
// slave is the cache, master is the IF stage / memory environment that drives it.
interface icache_responder_if;
  logic [31:0] pc_addr;
  logic        cache_ready;
  logic [31:0] instr_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output pc_addr,
    output mem_rdata,
    output mem_rvalid,
    input  cache_ready,
    input  instr_out,
    input  mem_req,
    input  mem_addr
  );

  modport slave (
    input  pc_addr,
    input  mem_rdata,
    input  mem_rvalid,
    output cache_ready,
    output instr_out,
    output mem_req,
    output mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hit path, blocking
// in-order line refill from a burst memory port on a miss.
module icache_responder #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  icache_responder_if.slave bus
);

  localparam int OB     = $clog2(WORDS_PER_LINE);
  localparam int IB     = $clog2(LINES);
  localparam int TAG_W  = 32 - OB - IB - 2;
  localparam int LINE_W = 32 - OB - 2;
  localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS_PER_LINE - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t              state_r;
  logic [OB-1:0]       beat_r;
  logic [LINE_W-1:0]   line_r;
  logic                mem_req_r;
  logic [31:0]         mem_addr_r;
  logic [LINES-1:0]    valid_r;
  logic [TAG_W-1:0]    tag_r  [LINES];
  logic [31:0]         data_r [LINES][WORDS_PER_LINE];

  logic [OB-1:0]       pc_word_s;
  logic [IB-1:0]       pc_index_s;
  logic [TAG_W-1:0]    pc_tag_s;
  logic [IB-1:0]       fill_index_s;
  logic [TAG_W-1:0]    fill_tag_s;
  logic                hit_s;
  logic                fill_beat_s;
  logic                last_beat_s;
  logic [31:0]         instr_s;
  logic                unused_s;

  // Fetch address split and refill target split
  assign pc_word_s    = bus.pc_addr[OB+1:2];
  assign pc_index_s   = bus.pc_addr[OB+IB+1:OB+2];
  assign pc_tag_s     = bus.pc_addr[31:OB+IB+2];
  assign fill_index_s = line_r[IB-1:0];
  assign fill_tag_s   = line_r[LINE_W-1:IB];
  assign unused_s     = ^bus.pc_addr[1:0];

  assign hit_s       = (state_r == IDLE) && valid_r[pc_index_s] &&
                       (tag_r[pc_index_s] == pc_tag_s);
  assign fill_beat_s = (state_r == REFILL) && bus.mem_rvalid;
  assign last_beat_s = fill_beat_s && (beat_r == LAST_BEAT);

  // Hit-path instruction mux; the IF next-PC logic needs it in the same cycle
  always_comb begin
    instr_s = 32'h0000_0000;
    if (hit_s) begin
      instr_s = data_r[pc_index_s][pc_word_s];
    end else begin
      instr_s = 32'h0000_0000;
    end
  end

  assign bus.cache_ready = hit_s;
  assign bus.instr_out   = instr_s;
  assign bus.mem_req     = mem_req_r;
  assign bus.mem_addr    = mem_addr_r;

  // Refill FSM with valid bits, beat counter, latched line and registered memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      beat_r     <= {OB{1'b0}};
      line_r     <= {LINE_W{1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      valid_r    <= {LINES{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!hit_s) begin
            // Invalidate first so a half-written line can never hit
            valid_r[pc_index_s] <= 1'b0;
            line_r              <= bus.pc_addr[31:OB+2];
            beat_r              <= {OB{1'b0}};
            mem_req_r           <= 1'b1;
            mem_addr_r          <= {bus.pc_addr[31:OB+2], {(OB+2){1'b0}}};
            state_r             <= REFILL;
          end else begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            state_r    <= IDLE;
          end
        end
        REFILL: begin
          if (bus.mem_rvalid) begin
            beat_r <= beat_r + {{(OB-1){1'b0}}, 1'b1};
            if (beat_r == LAST_BEAT) begin
              valid_r[fill_index_s] <= 1'b1;
              mem_req_r             <= 1'b0;
              mem_addr_r            <= 32'h0000_0000;
              state_r               <= IDLE;
            end else begin
              state_r <= REFILL;
            end
          end else begin
            state_r <= REFILL;
          end
        end
        default: begin
          state_r    <= IDLE;
          mem_req_r  <= 1'b0;
          mem_addr_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Tag and data storage, written only by refill beats and left unreset
  always_ff @(posedge clk) begin
    if (fill_beat_s) begin
      data_r[fill_index_s][beat_r] <= bus.mem_rdata;
    end
    if (last_beat_s) begin
      tag_r[fill_index_s] <= fill_tag_s;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: per-cycle vector table plus hand-written
// sequences for gapped/redirected refill and reset during refill.
module tb_icache_responder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  icache_responder_if bus_if ();

  icache_responder #(
    .LINES         (64),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic [31:0] ei;
    logic        eq;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                              input logic er, input logic [31:0] ei,
                              input logic eq, input logic [31:0] ea);
    vec_t v;
    v.pc = pc; v.rv = rv; v.rd = rd; v.er = er; v.ei = ei; v.eq = eq; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic er, input logic [31:0] ei,
                            input logic eq, input logic [31:0] ea);
    chk({nm, ".cache_ready"}, {31'd0, bus_if.cache_ready}, {31'd0, er});
    chk({nm, ".instr_out"},   bus_if.instr_out, ei);
    chk({nm, ".mem_req"},     {31'd0, bus_if.mem_req}, {31'd0, eq});
    chk({nm, ".mem_addr"},    bus_if.mem_addr, ea);
  endtask

  // Entered at posedge+2: drive, settle, compare, advance to the next posedge+2
  task automatic cyc(input string nm, input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                     input logic er, input logic [31:0] ei, input logic eq, input logic [31:0] ea);
    bus_if.pc_addr    = pc;
    bus_if.mem_rvalid = rv;
    bus_if.mem_rdata  = rd;
    #1;
    check_outs(nm, er, ei, eq, ea);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_if.pc_addr    = 32'hBFC0_0000;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_rdata  = 32'h0;

    // Cold miss, sequential hits, stray beat in IDLE, conflict eviction
    tbl.push_back(mk(32'hBFC0_0000, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'h11,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'h22,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'h33,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'h44,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b0, 32'h0,         1'b1, 32'h11, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0004, 1'b0, 32'h0,         1'b1, 32'h22, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0008, 1'b0, 32'h0,         1'b1, 32'h33, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_000C, 1'b0, 32'h0,         1'b1, 32'h44, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'hDEADBEEF,  1'b1, 32'h11, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0000, 1'b0, 32'h0,         1'b1, 32'h11, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0006, 1'b0, 32'h0,         1'b1, 32'h22, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0400, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0400, 1'b1, 32'hA0,        1'b0, 32'h0,  1'b1, 32'hBFC0_0400));
    tbl.push_back(mk(32'hBFC0_0400, 1'b1, 32'hA1,        1'b0, 32'h0,  1'b1, 32'hBFC0_0400));
    tbl.push_back(mk(32'hBFC0_0400, 1'b1, 32'hA2,        1'b0, 32'h0,  1'b1, 32'hBFC0_0400));
    tbl.push_back(mk(32'hBFC0_0400, 1'b1, 32'hA3,        1'b0, 32'h0,  1'b1, 32'hBFC0_0400));
    tbl.push_back(mk(32'hBFC0_0400, 1'b0, 32'h0,         1'b1, 32'hA0, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_040C, 1'b0, 32'h0,         1'b1, 32'hA3, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0000, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0000, 1'b0, 32'h0,         1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'hB0,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'hB1,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'hB2,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b1, 32'hB3,        1'b0, 32'h0,  1'b1, 32'hBFC0_0000));
    tbl.push_back(mk(32'hBFC0_0000, 1'b0, 32'h0,         1'b1, 32'hB0, 1'b0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0008, 1'b0, 32'h0,         1'b1, 32'hB2, 1'b0, 32'h0));

    repeat (2) @(posedge clk);
    #2;
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("row%0d", i), tbl[i].pc, tbl[i].rv, tbl[i].rd,
          tbl[i].er, tbl[i].ei, tbl[i].eq, tbl[i].ea);
    end

    // Gapped burst at 0x1000 with an IF redirect to 0x2000 mid-burst
    cyc("gap0",  32'h0000_1000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0);
    cyc("gap1",  32'h0000_1000, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap2",  32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap3",  32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap4",  32'h0000_2000, 1'b1, 32'hC1, 1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap5",  32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap6",  32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap7",  32'h0000_2000, 1'b1, 32'hC2, 1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap8",  32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap9",  32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap10", 32'h0000_2000, 1'b1, 32'hC3, 1'b0, 32'h0, 1'b1, 32'h0000_1000);
    cyc("gap11", 32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0);
    cyc("gap12", 32'h0000_2000, 1'b1, 32'hD0, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
    cyc("gap13", 32'h0000_2000, 1'b1, 32'hD1, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
    cyc("gap14", 32'h0000_2000, 1'b1, 32'hD2, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
    cyc("gap15", 32'h0000_2000, 1'b1, 32'hD3, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
    cyc("gap16", 32'h0000_2000, 1'b0, 32'h0,  1'b1, 32'hD0, 1'b0, 32'h0);
    cyc("gap17", 32'h0000_200C, 1'b0, 32'h0,  1'b1, 32'hD3, 1'b0, 32'h0);

    // Reset after two of four beats; a valid line elsewhere must not hit during REFILL
    cyc("rr0", 32'h0000_3010, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rr1", 32'h0000_2004, 1'b1, 32'hE0, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
    cyc("rr2", 32'h0000_3010, 1'b1, 32'hE1, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
    rst = 1'b1;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'hE2;
    #1;
    check_outs("rr_async", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    bus_if.mem_rdata = 32'hE3;
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc("rr3", 32'h0000_3010, 1'b1, 32'hE3, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rr4", 32'h0000_3010, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0000_3010);
    cyc("rr5", 32'h0000_3010, 1'b1, 32'hF0, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
    cyc("rr6", 32'h0000_3010, 1'b1, 32'hF1, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
    cyc("rr7", 32'h0000_3010, 1'b1, 32'hF2, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
    cyc("rr8", 32'h0000_3010, 1'b1, 32'hF3, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
    cyc("rr9", 32'h0000_3010, 1'b0, 32'h0,  1'b1, 32'hF0, 1'b0, 32'h0);
    cyc("rr10", 32'h0000_3014, 1'b0, 32'h0, 1'b1, 32'hF1, 1'b0, 32'h0);
    cyc("rr11", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
# icache_responder

Direct-mapped, read-only instruction cache serving the IF stage. It takes the fetch PC each cycle and returns the instruction with `cache_ready` in the same cycle on a hit. On a miss it holds `cache_ready` low, refills the whole line from a burst memory port, then serves the fetch. It sits between the IF stage's PC register and the instruction memory or bus.

## Interface
- `LINES`, 64: number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, at least 2.
- `clk`  in  1  — the single clock; every register updates on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `pc_addr`  in  32  — fetch address from the IF stage; bits [1:0] ignored.
- `cache_ready`  out  1  — instruction valid this cycle; the IF stage stalls while low.
- `instr_out`  out  32  — fetched instruction; 32'h0 whenever `cache_ready`=0.
- `mem_req`  out  1  — refill burst request; held high for the whole burst.
- `mem_addr`  out  32  — line-aligned refill address; stable while `mem_req`=1, else 0.
- `mem_rdata`  in  32  — refill data beat.
- `mem_rvalid`  in  1  — `mem_rdata` valid this cycle; one word per beat.

## Operation
- Address split, using OB = log2(WORDS_PER_LINE) and IB = log2(LINES):
  - word select = pc[OB+1:2]
  - index = pc[OB+IB+1:OB+2]
  - tag = pc[31:OB+IB+2]
  - Defaults: word [3:2], index [9:4], tag [31:10].
- Storage: per-line valid bit, tag register and data words, all in flops with combinational read.
- hit = (state==IDLE) && valid[index] && tag[index]==pc tag.
- `cache_ready` = hit. `instr_out` = data[index][word] when hit, else 0.
- FSM states: IDLE, REFILL.
  - IDLE, hit: stay in IDLE.
  - IDLE, miss: latch the line address {pc[31:OB+2], zeros}, clear the beat counter, go to REFILL.
  - REFILL: `mem_req`=1 and `mem_addr`=latched address. Each `mem_rvalid` writes `mem_rdata` to data[latched index][beat counter] and increments the counter.
  - On the beat where the counter equals WORDS_PER_LINE-1: set valid and write the tag for that line, drop `mem_req` next cycle, return to IDLE.
- Beats arrive strictly in order, word 0 first. There is no critical-word-first.
- Refill always fills the line at the latched address. A PC change during REFILL (IF redirect) does not abort the burst. After the return to IDLE, the current `pc_addr` is looked up afresh and may miss again.
- The line being refilled has valid cleared on the miss edge, so a partially written line never reports a hit.
- `mem_rvalid` in IDLE is ignored: no storage write, no state change.
- `cache_ready` is never 1 in REFILL, even if `pc_addr` matches another valid line. Fetch is blocking.

## Timing
- Reset, asynchronous:
  - All valid bits 0, state IDLE, beat counter 0, latched address 0.
  - `mem_req`=0, `mem_addr`=0, `cache_ready`=0, `instr_out`=0, effective immediately.
  - Tag and data arrays are not reset.
- Hit latency: 0 cycles. `pc_addr` to `cache_ready` and `instr_out` is combinational, because the IF stage's next-PC mux uses it the same cycle.
- Miss, with the miss seen in cycle t:
  - `mem_req` rises at t+1.
  - With beats at t+1+d … t+d+WORDS_PER_LINE (memory latency d ≥ 0), the last beat is written at that edge.
  - IDLE and `mem_req`=0 at t+d+WORDS_PER_LINE+1.
  - Hit, with the PC unchanged, in that same cycle.
  - Miss penalty = WORDS_PER_LINE + d + 1 cycles.
- Gaps between beats are allowed; the counter only advances on `mem_rvalid`.
- Reset during REFILL aborts the burst. Late `mem_rvalid` beats after reset are ignored.

## Test plan
- Reset cold miss: release `rst`, `pc_addr`=0xBFC00000 (tag 0x2FF000, index 0) → `cache_ready`=0, `mem_req`=1 with `mem_addr`=0xBFC00000 next cycle. Return 4 beats 0x11,0x22,0x33,0x44 back-to-back → one cycle after the last beat, `cache_ready`=1 and `instr_out`=0x11.
- Sequential hits: after the refill above, `pc_addr` 0xBFC00004 then 0xBFC00008 then 0xBFC0000C → `cache_ready`=1 each cycle, `instr_out`=0x22, 0x33, 0x44, and `mem_req` stays 0.
- Conflict eviction: fill 0xBFC00000, then fetch 0xBFC00400 (same index 0, different tag) → miss, refill at 0xBFC00400. Re-fetch 0xBFC00000 → miss again.
- Gapped burst with redirect: miss on 0x00001000, beats with 2 idle cycles between each, `pc_addr` changed to 0x00002000 mid-burst → refill still completes at `mem_addr` 0x00001000, then a new miss is issued for 0x00002000.
- Reset mid-refill: assert `rst` after 2 of 4 beats → `mem_req` drops immediately. The remaining beats are ignored. A fetch of the same address after release misses, with no partial hit.
- Stray data: `mem_rvalid`=1 with 0xDEADBEEF in IDLE → no state change, and cached contents unchanged on the next hit.
